// File: rtl/cfu_simd_mac.sv
// Packed-SIMD multiply-accumulate CFU with a bank of accumulators and an input offset.
// Keeps the legacy single-cycle OR and serialises lane products over N busy cycles.
module cfu_simd_mac #(
  parameter int LANE_W       = 8,
  parameter int MACS_PER_CYC = 1,
  parameter int NUM_ACC      = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        stall_o,
  output logic [31:0] rslt_o
);

  localparam int LANES = 32 / LANE_W;
  localparam int N     = LANES / MACS_PER_CYC;
  localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int ACC_N = 1 << SEL_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * LANE_W + 2;
  localparam int EW    = (PW > 32) ? PW : 32;
  localparam int STEP  = MACS_PER_CYC * LANE_W;

  localparam logic [2:0] OP_OR     = 3'd0;
  localparam logic [2:0] OP_MAC    = 3'd1;
  localparam logic [2:0] OP_RD     = 3'd2;
  localparam logic [2:0] OP_CLR    = 3'd3;
  localparam logic [2:0] OP_SETOFF = 3'd4;
  localparam logic [2:0] OP_DOT    = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                  r_state;
  logic [31:0]             r_acc [ACC_N];
  logic signed [LANE_W:0]  r_off;
  logic [31:0]             r_a;
  logic [31:0]             r_b;
  logic [31:0]             r_psum;
  logic [31:0]             r_rslt;
  logic                    r_isMac;
  logic [SEL_W-1:0]        r_sel;
  logic [CNT_W-1:0]        r_cnt;

  logic [SEL_W-1:0]        w_sel;
  logic                    w_issue;
  logic                    w_issueMulti;
  logic                    w_last;
  logic [31:0]             w_accSel;
  logic [31:0]             w_stepSum;
  logic signed [LANE_W+1:0] w_opA;
  logic signed [PW-1:0]    w_prod;
  logic signed [EW-1:0]    w_prodExt;
  logic                    w_unused;

  // Accumulator index wraps modulo NUM_ACC; only funct7[2:0] carries it.
  assign w_sel        = SEL_W'(funct7_i[2:0] & 3'(NUM_ACC - 1));
  assign w_accSel     = r_acc[w_sel];
  assign w_issue      = (r_state == S_IDLE) && en_i;
  assign w_issueMulti = w_issue && ((funct3_i == OP_MAC) || (funct3_i == OP_DOT));
  assign w_last       = (r_cnt == CNT_W'(N - 1));
  assign w_unused     = ^funct7_i[6:3];

  // Operand latches shift right each busy cycle, so the low lanes are always the next ones.
  always_comb begin
    w_stepSum = r_psum;
    w_opA     = '0;
    w_prod    = '0;
    w_prodExt = '0;
    for (int j = 0; j < MACS_PER_CYC; j++) begin
      w_opA     = $signed({{2{r_a[j*LANE_W+LANE_W-1]}}, r_a[j*LANE_W +: LANE_W]})
                + $signed({r_off[LANE_W], r_off});
      w_prod    = PW'(w_opA) * PW'($signed(r_b[j*LANE_W +: LANE_W]));
      w_prodExt = EW'(w_prod);
      w_stepSum = w_stepSum + w_prodExt[31:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_off   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_rslt  <= '0;
      r_isMac <= 1'b0;
      r_sel   <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < ACC_N; i++) r_acc[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            case (funct3_i)
              OP_MAC, OP_DOT: begin
                r_state <= S_BUSY;
                r_a     <= src1_i;
                r_b     <= src2_i;
                r_isMac <= (funct3_i == OP_MAC);
                r_sel   <= w_sel;
                r_cnt   <= '0;
                r_psum  <= '0;
              end
              OP_CLR:    r_acc[w_sel] <= '0;
              OP_SETOFF: r_off <= src1_i[LANE_W:0];
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          r_psum <= w_stepSum;
          r_a    <= r_a >> STEP;
          r_b    <= r_b >> STEP;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_rslt  <= r_isMac ? (r_acc[r_sel] + w_stepSum) : w_stepSum;
            if (r_isMac) r_acc[r_sel] <= r_acc[r_sel] + w_stepSum;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so nothing leaks onto the core's OR'd writeback path.
  always_comb begin
    rslt_o = '0;
    if (rst_ni) begin
      if (r_state == S_DONE) begin
        rslt_o = r_rslt;
      end else if (w_issue) begin
        case (funct3_i)
          OP_OR:         rslt_o = src1_i | src2_i;
          OP_RD, OP_CLR: rslt_o = w_accSel;
          default:       rslt_o = '0;
        endcase
      end
    end
  end

  assign stall_o = rst_ni && (w_issueMulti || (r_state == S_BUSY));

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Randomised bench for cfu_simd_mac: a default instance plus a wide-lane single-accumulator one,
// both checked against a plain-arithmetic model of dot products, accumulators and offset.
module tb_cfu_simd_mac;

  logic        clk;
  logic        rst_n;
  logic        en8;
  logic        enW;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stall8;
  logic        stallW;
  logic [31:0] rslt8;
  logic [31:0] rsltW;

  int total = 0;
  int bad   = 0;
  int accM [2][4];
  int offM [2];

  cfu_simd_mac #(.LANE_W(8), .MACS_PER_CYC(1), .NUM_ACC(4)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en8), .funct3_i(funct3), .funct7_i(funct7),
    .src1_i(src1), .src2_i(src2), .stall_o(stall8), .rslt_o(rslt8)
  );

  cfu_simd_mac #(.LANE_W(16), .MACS_PER_CYC(2), .NUM_ACC(1)) u_dutW (
    .clk_i(clk), .rst_ni(rst_n), .en_i(enW), .funct3_i(funct3), .funct7_i(funct7),
    .src1_i(src1), .src2_i(src2), .stall_o(stallW), .rslt_o(rsltW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, obs, expv);
    end
  endtask

  function automatic int dotModel(input logic [31:0] a, input logic [31:0] b, input int off, input int lw);
    longint s = 0;
    longint ai;
    longint bi;
    for (int i = 0; i < 32 / lw; i++) begin
      if (lw == 8) begin
        ai = longint'($signed(a[i*8 +: 8]));
        bi = longint'($signed(b[i*8 +: 8]));
      end else begin
        ai = longint'($signed(a[i*16 +: 16]));
        bi = longint'($signed(b[i*16 +: 16]));
      end
      s += (ai + off) * bi;
    end
    return int'(s);
  endfunction

  function automatic logic [31:0] rsltOf(input bit wide);
    return wide ? rsltW : rslt8;
  endfunction

  function automatic logic [31:0] stallOf(input bit wide);
    return wide ? 32'(stallW) : 32'(stall8);
  endfunction

  task automatic resetModel();
    for (int w = 0; w < 2; w++) begin
      offM[w] = 0;
      for (int s = 0; s < 4; s++) accM[w][s] = 0;
    end
  endtask

  task automatic scramble();
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    src1   = $urandom;
    src2   = $urandom;
  endtask

  // One operation on the chosen instance; hold keeps en high with junk operands until DONE ends.
  task automatic applyStimulus(input bit wide, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b, input bit hold);
    int w    = wide ? 1 : 0;
    int sel  = wide ? 0 : int'(f7[2:0]) % 4;
    int lw   = wide ? 16 : 8;
    int n    = wide ? 1 : 4;
    int expv;
    @(negedge clk);
    en8 = !wide; enW = wide; funct3 = f3; funct7 = f7; src1 = a; src2 = b;
    #1;
    if (f3 == 3'd1 || f3 == 3'd5) begin
      expv = dotModel(a, b, offM[w], lw);
      if (f3 == 3'd1) expv += accM[w][sel];
      checkOutput("issueStall", stallOf(wide), 32'd1);
      checkOutput("issueRslt", rsltOf(wide), 32'd0);
      @(posedge clk);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        if (hold) scramble(); else begin en8 = 1'b0; enW = 1'b0; end
        #1;
        checkOutput("busyStall", stallOf(wide), 32'd1);
        checkOutput("busyRslt", rsltOf(wide), 32'd0);
      end
      @(negedge clk);
      if (hold) scramble(); else begin en8 = 1'b0; enW = 1'b0; end
      #1;
      checkOutput("doneStall", stallOf(wide), 32'd0);
      checkOutput(f3 == 3'd1 ? "macRslt" : "dotRslt", rsltOf(wide), 32'(expv));
      if (f3 == 3'd1) accM[w][sel] = expv;
      @(posedge clk);
    end else begin
      case (f3)
        3'd0:       expv = int'(a | b);
        3'd2, 3'd3: expv = accM[w][sel];
        default:    expv = 0;
      endcase
      checkOutput("singleRslt", rsltOf(wide), 32'(expv));
      checkOutput("singleStall", stallOf(wide), 32'd0);
      @(posedge clk);
      if (f3 == 3'd3) accM[w][sel] = 0;
      if (f3 == 3'd4) offM[w] = wide ? int'($signed(a[16:0])) : int'($signed(a[8:0]));
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    en8 = 1'b0; enW = 1'b0;
    scramble();
    #1;
    checkOutput("idleRslt8", rslt8, 32'd0);
    checkOutput("idleStall8", 32'(stall8), 32'd0);
    checkOutput("idleRsltW", rsltW, 32'd0);
    checkOutput("idleStallW", 32'(stallW), 32'd0);
    @(posedge clk);
  endtask

  task automatic resetInBusy();
    @(negedge clk);
    en8 = 1'b1; enW = 1'b0; funct3 = 3'd1; funct7 = 7'd1; src1 = 32'h7F7F7F7F; src2 = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    en8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstBusyStall", 32'(stall8), 32'd0);
    checkOutput("rstBusyRslt", rslt8, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    @(posedge clk);
  endtask

  initial begin
    resetModel();
    rst_n = 1'b0; en8 = 1'b1; enW = 1'b1;
    funct3 = 3'd0; funct7 = 7'd0; src1 = 32'hF0F0_1234; src2 = 32'h0A0A_5678;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetRslt8", rslt8, 32'd0);
    checkOutput("resetStall8", 32'(stall8), 32'd0);
    checkOutput("resetRsltW", rsltW, 32'd0);
    @(negedge clk);
    en8 = 1'b0; enW = 1'b0; rst_n = 1'b1;
    @(posedge clk);

    applyStimulus(0, 3'd0, 7'd0, 32'h00F0_000F, 32'h0F00_00F0, 0);
    idleCycle();
    applyStimulus(0, 3'd5, 7'd0, 32'h0102_0304, 32'h0506_0708, 0);
    for (int s = 0; s < 4; s++) applyStimulus(0, 3'd2, 7'(s), 32'd0, 32'd0, 0);
    applyStimulus(0, 3'd5, 7'd0, 32'hFFFF_FFFF, 32'h0101_0101, 0);
    applyStimulus(0, 3'd4, 7'd0, 32'h0000_0080, 32'd0, 0);
    applyStimulus(0, 3'd5, 7'd0, 32'h0102_0304, 32'h0506_0708, 0);
    applyStimulus(0, 3'd4, 7'd0, 32'd0, 32'd0, 0);
    applyStimulus(0, 3'd1, 7'd2, 32'h0102_0304, 32'h0506_0708, 0);
    applyStimulus(0, 3'd1, 7'd2, 32'h0102_0304, 32'h0506_0708, 0);
    applyStimulus(0, 3'd2, 7'd2, 32'd0, 32'd0, 0);
    applyStimulus(0, 3'd2, 7'd1, 32'd0, 32'd0, 0);
    applyStimulus(0, 3'd3, 7'd2, 32'd0, 32'd0, 0);
    applyStimulus(0, 3'd2, 7'd2, 32'd0, 32'd0, 0);
    applyStimulus(0, 3'd1, 7'd6, 32'h0102_0304, 32'h0506_0708, 0);
    applyStimulus(0, 3'd2, 7'd2, 32'd0, 32'd0, 0);
    applyStimulus(0, 3'd1, 7'd0, 32'h0102_0304, 32'h0506_0708, 1);
    applyStimulus(0, 3'd2, 7'd0, 32'd0, 32'd0, 0);
    applyStimulus(0, 3'd6, 7'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(0, 3'd7, 7'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    resetInBusy();
    for (int s = 0; s < 4; s++) applyStimulus(0, 3'd2, 7'(s), 32'd0, 32'd0, 0);

    applyStimulus(1, 3'd5, 7'd0, 32'hFFFF_0003, 32'h0002_0004, 0);
    applyStimulus(1, 3'd1, 7'd5, 32'hFFFF_0003, 32'h0002_0004, 0);
    applyStimulus(1, 3'd2, 7'd3, 32'd0, 32'd0, 0);
    idleCycle();

    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a = a & 32'h0707_0707;
        b = b & 32'h0707_0707;
      end
      applyStimulus($urandom_range(0, 3) == 0, 3'($urandom), 7'($urandom), a, b, 1'($urandom));
      if ($urandom_range(0, 7) == 0) idleCycle();
    end
    idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
